// File: rtl/y_sram_responder_pkg.sv
// Shared Y-path definitions: default geometry of the Y SRAM and the bus-owner states
// used by the arbiter and the responder.
package y_sram_responder_pkg;

  localparam int          Y_ADDR_W    = 11;
  localparam int          Y_DATA_W    = 256;
  localparam int          Y_DEPTH     = 2048;
  localparam logic [10:0] Y_NULL_ADDR = 11'h7ff;

  typedef enum logic [1:0] {
    OWN_CTRL = 2'd0,
    OWN_WR   = 2'd1,
    OWN_ERR  = 2'd2
  } owner_e;

  // Owner implied by the enable pair; both asserted is illegal and routes as control.
  function automatic owner_e owner_from_en(input logic compute_en, input logic write_en);
    owner_e owner;
    owner = OWN_CTRL;
    if (compute_en && write_en)
      owner = OWN_ERR;
    else if (write_en)
      owner = OWN_WR;
    return owner;
  endfunction

endpackage

// File: rtl/y_sram_2r1w.sv
// DEPTH x DATA_W storage with one write port and two registered read ports.
// Same-cycle reads of the write address return the write data; NULL_ADDR is the idle address.
module y_sram_2r1w
  import y_sram_responder_pkg::*;
#(
  parameter int                ADDR_W    = Y_ADDR_W,
  parameter int                DATA_W    = Y_DATA_W,
  parameter int                DEPTH     = Y_DEPTH,
  parameter logic [ADDR_W-1:0] NULL_ADDR = ADDR_W'(Y_NULL_ADDR)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic              o_wr_acc,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_rvld1,
  output logic [DATA_W-1:0] o_rdata2,
  output logic              o_rvld2
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;
  logic              r_rvld1;
  logic              r_rvld2;
  logic              w_wr_acc;
  logic              w_rd1_req;
  logic              w_rd2_req;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  assign w_wr_acc  = i_reset_n && i_we && (i_waddr != NULL_ADDR);
  assign w_rd1_req = (i_raddr1 != NULL_ADDR);
  assign w_rd2_req = (i_raddr2 != NULL_ADDR);

  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (w_rd1_req)
      w_rd1 = (w_wr_acc && (i_waddr == i_raddr1)) ? i_wdata : r_mem[i_raddr1];
    if (w_rd2_req)
      w_rd2 = (w_wr_acc && (i_waddr == i_raddr2)) ? i_wdata : r_mem[i_raddr2];
  end

  // Contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc)
      r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_rvld1  <= 1'b0;
      r_rvld2  <= 1'b0;
    end else begin
      r_rdata1 <= w_rd1;
      r_rdata2 <= w_rd2;
      r_rvld1  <= w_rd1_req;
      r_rvld2  <= w_rd2_req;
    end
  end

  assign o_wr_acc = w_wr_acc;
  assign o_rdata1 = r_rdata1;
  assign o_rdata2 = r_rdata2;
  assign o_rvld1  = r_rvld1;
  assign o_rvld2  = r_rvld2;

endmodule

// File: rtl/y_sram_responder.sv
// Y SRAM responder: 1-cycle reads routed to the owner (control or write path) that issued them,
// plus owner FSM, sticky protocol-error flag and accepted-write counter.
module y_sram_responder
  import y_sram_responder_pkg::*;
#(
  parameter int                ADDR_W    = Y_ADDR_W,
  parameter int                DATA_W    = Y_DATA_W,
  parameter int                DEPTH     = Y_DEPTH,
  parameter logic [ADDR_W-1:0] NULL_ADDR = ADDR_W'(Y_NULL_ADDR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_yComputeModuleEnable,
  input  logic              in_yWriteModuleEnable,
  input  logic [ADDR_W-1:0] in_yReadAddress1,
  input  logic [ADDR_W-1:0] in_yReadAddress2,
  input  logic              in_yWriteEnable,
  input  logic [ADDR_W-1:0] in_yWriteAddress,
  input  logic [DATA_W-1:0] in_writeData,
  output logic [DATA_W-1:0] op_ctrlReadData1,
  output logic [DATA_W-1:0] op_ctrlReadData2,
  output logic              op_ctrlReadValid1,
  output logic              op_ctrlReadValid2,
  output logic [DATA_W-1:0] op_wrReadData1,
  output logic [DATA_W-1:0] op_wrReadData2,
  output logic              op_wrReadValid1,
  output logic              op_wrReadValid2,
  output logic [15:0]       op_writeCount,
  output logic              op_protocolErr
);

  owner_e            r_state;
  owner_e            w_state_nxt;
  logic              r_tag_wr;
  logic              r_err;
  logic [15:0]       r_wr_cnt;
  logic              w_wr_acc;
  logic              w_err_entry;
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;
  logic              w_rvld1;
  logic              w_rvld2;

  y_sram_2r1w #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .NULL_ADDR (NULL_ADDR)
  ) u_sram (
    .i_clk     (clk),
    .i_reset_n (reset),
    .i_we      (in_yWriteEnable),
    .i_waddr   (in_yWriteAddress),
    .i_wdata   (in_writeData),
    .i_raddr1  (in_yReadAddress1),
    .i_raddr2  (in_yReadAddress2),
    .o_wr_acc  (w_wr_acc),
    .o_rdata1  (w_rdata1),
    .o_rvld1   (w_rvld1),
    .o_rdata2  (w_rdata2),
    .o_rvld2   (w_rvld2)
  );

  always_ff @(posedge clk) begin
    if (!reset)
      r_state <= OWN_CTRL;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = owner_from_en(in_yComputeModuleEnable, in_yWriteModuleEnable);
    w_err_entry = (r_state != OWN_ERR) && (w_state_nxt == OWN_ERR);
  end

  // The tag travels with the read so a later owner switch cannot steal its data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tag_wr <= 1'b0;
      r_err    <= 1'b0;
      r_wr_cnt <= '0;
    end else begin
      r_tag_wr <= (w_state_nxt == OWN_WR);
      if (w_err_entry)
        r_err <= 1'b1;
      if (w_wr_acc)
        r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  assign op_ctrlReadData1  = r_tag_wr ? '0 : w_rdata1;
  assign op_ctrlReadData2  = r_tag_wr ? '0 : w_rdata2;
  assign op_ctrlReadValid1 = !r_tag_wr && w_rvld1;
  assign op_ctrlReadValid2 = !r_tag_wr && w_rvld2;
  assign op_wrReadData1    = r_tag_wr ? w_rdata1 : '0;
  assign op_wrReadData2    = r_tag_wr ? w_rdata2 : '0;
  assign op_wrReadValid1   = r_tag_wr && w_rvld1;
  assign op_wrReadValid2   = r_tag_wr && w_rvld2;
  assign op_writeCount     = r_wr_cnt;
  assign op_protocolErr    = r_err;

endmodule
